// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the pipeline stages.
//   - bus widths between EX/MS and MS/WS
//   - load-operation codes carried on the EX->MS bus
//   - memory-stage state encoding
//   - packed view of the EX->MS bus
package cpu_pkg;

    localparam int unsigned ES_MS_BUS_W = 75;
    localparam int unsigned MS_WS_BUS_W = 70;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_READY = 2'd2
    } ms_state_e;

    // First member is the MSB, matching {pc, gr_we, dest, alu_result,
    // res_from_mem, ld_op, mem_req}.
    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic [2:0]  ld_op;
        logic        mem_req;
    } es_ms_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline handshake signals around the memory stage.
//   es_to_ms_valid / es_ms_bus / ms_allow_in : EX -> MS hand-off
//   ms_to_ws_valid / ms_ws_bus / ws_allow_in : MS -> WS hand-off
// slave  : the memory stage's view
// master : the surrounding pipeline's (or a bench's) view
interface mem_stage_if;
    import cpu_pkg::*;

    logic                   es_to_ms_valid;
    logic [ES_MS_BUS_W-1:0] es_ms_bus;
    logic                   ms_allow_in;
    logic                   ms_to_ws_valid;
    logic [MS_WS_BUS_W-1:0] ms_ws_bus;
    logic                   ws_allow_in;

    modport slave (
        input  es_to_ms_valid,
        input  es_ms_bus,
        input  ws_allow_in,
        output ms_allow_in,
        output ms_to_ws_valid,
        output ms_ws_bus
    );

    modport master (
        output es_to_ms_valid,
        output es_ms_bus,
        output ws_allow_in,
        input  ms_allow_in,
        input  ms_to_ws_valid,
        input  ms_ws_bus
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data alignment and extension.
//   mem_word  in  32 : raw memory word
//   a         in  2  : byte offset within the word
//   ld_op     in  3  : load operation code (unknown codes act as ld.w)
//   load_data out 32 : aligned, sign-/zero-extended result
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  a,
    input  logic [2:0]  ld_op,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_word[7:0];
        case (a)
            2'd0: byte_sel = mem_word[7:0];
            2'd1: byte_sel = mem_word[15:8];
            2'd2: byte_sel = mem_word[23:16];
            2'd3: byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
        half_sel = a[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = mem_word;
        case (ld_op)
            LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_data = {24'd0, byte_sel};
            LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_data = {16'd0, half_sel};
            default: load_data = mem_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
//   clk, resetn        : clock, asynchronous active-low reset
//   pipe (slave)       : EX->MS and MS->WS valid/allow-in handshakes
//   data_sram_data_ok  : data-memory response strobe
//   data_sram_rdata    : read data, valid with data_ok
//   ms_dest_reg        : destination register while a writing op is held
//   ms_rf_fwd          : {fwd_valid, dest, final_result} for forwarding
module mem_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  pipe,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [4:0]  ms_dest_reg,
    output logic [37:0] ms_rf_fwd
);

    ms_state_e   state_q, state_d;
    es_ms_bus_t  bus_q, bus_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] data_buf_q, data_buf_d;

    logic        ms_valid;
    logic        ms_ready_go;
    logic        accept;
    logic        handoff;
    logic [31:0] mem_word;
    logic [31:0] load_data;
    logic [31:0] final_result;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= MS_EMPTY;
            bus_q       <= '0;
            buf_valid_q <= 1'b0;
            data_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            buf_valid_q <= buf_valid_d;
            data_buf_q  <= data_buf_d;
        end
    end

    // Next-state logic. Later assignments take priority: a new instruction
    // overrides a hand-off, which overrides buffering a response.
    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        buf_valid_d = buf_valid_q;
        data_buf_d  = data_buf_q;

        // Response while writeback is stalled: keep the word for later.
        if (state_q == MS_WAIT && data_sram_data_ok && !pipe.ws_allow_in) begin
            state_d     = MS_READY;
            buf_valid_d = 1'b1;
            data_buf_d  = data_sram_rdata;
        end

        if (handoff) begin
            state_d     = MS_EMPTY;
            buf_valid_d = 1'b0;
        end

        if (accept) begin
            bus_d       = es_ms_bus_t'(pipe.es_ms_bus);
            buf_valid_d = 1'b0;
            state_d     = pipe.es_ms_bus[0] ? MS_WAIT : MS_READY;
        end
    end

    // Output / handshake logic
    always_comb begin
        ms_valid    = (state_q != MS_EMPTY);
        ms_ready_go = !bus_q.mem_req || data_sram_data_ok || buf_valid_q;

        pipe.ms_to_ws_valid = ms_valid && ms_ready_go;
        pipe.ms_allow_in    = !ms_valid || (ms_ready_go && pipe.ws_allow_in);

        accept  = pipe.es_to_ms_valid && pipe.ms_allow_in;
        handoff = pipe.ms_to_ws_valid && pipe.ws_allow_in;

        mem_word     = buf_valid_q ? data_buf_q : data_sram_rdata;
        final_result = bus_q.res_from_mem ? load_data : bus_q.alu_result;

        pipe.ms_ws_bus = {bus_q.pc, bus_q.gr_we, bus_q.dest, final_result};
        ms_dest_reg    = (ms_valid && bus_q.gr_we) ? bus_q.dest : 5'd0;
        ms_rf_fwd      = {ms_valid && bus_q.gr_we && ms_ready_go,
                          bus_q.dest, final_result};
    end

    load_align u_load_align (
        .mem_word  (mem_word),
        .a         (bus_q.alu_result[1:0]),
        .ld_op     (bus_q.ld_op),
        .load_data (load_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        data_ok;
    logic [31:0] rdata;
    logic [4:0]  ms_dest_reg;
    logic [37:0] ms_rf_fwd;

    mem_stage_if ifc ();

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .pipe              (ifc),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .ms_dest_reg       (ms_dest_reg),
        .ms_rf_fwd         (ms_rf_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Behavioural model: the instruction currently held in the stage.
    bit          m_valid;
    logic [74:0] m_bus;
    bit          m_has_buf;
    logic [31:0] m_buf;
    bit          m_resp;
    int unsigned m_age;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [74:0] mk(input logic [31:0] pc, input logic we,
                                       input logic [4:0] dest, input logic [31:0] alu,
                                       input logic rfm, input logic [2:0] op,
                                       input logic req);
        return {pc, we, dest, alu, rfm, op, req};
    endfunction

    // Load result computed arithmetically from the word, offset and op code.
    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] op);
        int unsigned b, h, sh_b, sh_h;
        sh_b = 8 * int'(a);
        sh_h = 16 * int'(a[1]);
        b = (w >> sh_b) & 32'hFF;
        h = (w >> sh_h) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd3:    return b;
            3'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    task automatic m_reset();
        m_valid   = 0;
        m_has_buf = 0;
        m_resp    = 0;
        m_age     = 0;
        m_bus     = '0;
        m_buf     = '0;
    endtask

    // Expected combinational outputs given the model and the current inputs.
    task automatic expect_now(output bit ready, output bit allow, output logic [31:0] res);
        logic [31:0] word;
        ready = m_valid && (!m_bus[0] || m_has_buf || data_ok);
        allow = !m_valid || (ready && ifc.ws_allow_in);
        word  = m_has_buf ? m_buf : rdata;
        res   = m_bus[4] ? ld_model(word, m_bus[6:5], m_bus[3:1]) : m_bus[36:5];
    endtask

    // One cycle: compare outputs, then advance the model on the clock edge.
    task automatic step();
        bit ready, allow, leave, take;
        logic [31:0] res;
        #2;
        expect_now(ready, allow, res);
        chk("to_ws_valid", ifc.ms_to_ws_valid, ready);
        chk("allow_in", ifc.ms_allow_in, allow);
        chk("dest_reg", ms_dest_reg, (m_valid && m_bus[42]) ? m_bus[41:37] : 5'd0);
        chk("fwd_valid", ms_rf_fwd[37], ready && m_bus[42]);
        if (ready) begin
            chk("ws_bus", ifc.ms_ws_bus, {m_bus[74:43], m_bus[42], m_bus[41:37], res});
            chk("fwd_bus", ms_rf_fwd[36:0], {m_bus[41:37], res});
        end
        @(posedge clk);
        if (!resetn) begin
            m_reset();
        end else begin
            leave = ready && ifc.ws_allow_in;
            take  = ifc.es_to_ms_valid && allow;
            if (m_valid && m_bus[0] && !m_has_buf && data_ok && !leave) begin
                m_has_buf = 1;
                m_buf     = rdata;
            end
            if (m_valid && m_bus[0] && data_ok) m_resp = 1;
            if (m_valid) m_age++;
            if (leave) begin
                m_valid   = 0;
                m_has_buf = 0;
            end
            if (take) begin
                m_valid   = 1;
                m_bus     = ifc.es_ms_bus;
                m_has_buf = 0;
                m_resp    = 0;
                m_age     = 0;
            end
        end
        #1;
    endtask

    task automatic run_load(input string nm, input logic [2:0] op, input logic [31:0] alu,
                            input logic [31:0] word, input logic [31:0] expv);
        ifc.es_to_ms_valid = 1;
        ifc.es_ms_bus      = mk(32'h1C00_0100, 1'b1, 5'd7, alu, 1'b1, op, 1'b1);
        ifc.ws_allow_in    = 1;
        data_ok            = 0;
        #1; step();
        ifc.es_to_ms_valid = 0;
        #1; chk({nm, "_wait0"}, ifc.ms_to_ws_valid, 1'b0);
        chk({nm, "_wait0_allow"}, ifc.ms_allow_in, 1'b0);
        step();
        #1; chk({nm, "_wait1"}, ifc.ms_to_ws_valid, 1'b0);
        step();
        data_ok = 1;
        rdata   = word;
        #1; chk({nm, "_valid"}, ifc.ms_to_ws_valid, 1'b1);
        chk({nm, "_result"}, ifc.ms_ws_bus[31:0], expv);
        step();
        data_ok = 0;
    endtask

    initial begin
        logic [74:0] alu_bus;
        m_reset();
        resetn             = 0;
        data_ok            = 0;
        rdata              = '0;
        ifc.es_to_ms_valid = 0;
        ifc.es_ms_bus      = '0;
        ifc.ws_allow_in    = 1;

        // Reset state
        #1;
        chk("rst_allow", ifc.ms_allow_in, 1'b1);
        chk("rst_valid", ifc.ms_to_ws_valid, 1'b0);
        chk("rst_dest", ms_dest_reg, 5'd0);
        chk("rst_fwd", ms_rf_fwd, 38'd0);
        chk("rst_bus", ifc.ms_ws_bus, 70'd0);
        step();
        resetn = 1;

        // Stray response while empty
        data_ok = 1;
        rdata   = 32'h5A5A_A5A5;
        #1;
        chk("stray_valid", ifc.ms_to_ws_valid, 1'b0);
        chk("stray_bus", ifc.ms_ws_bus, 70'd0);
        chk("stray_fwd", ms_rf_fwd, 38'd0);
        step();
        data_ok = 0;

        // ALU pass-through
        alu_bus = mk(32'h1C00_0000, 1'b1, 5'd5, 32'h1234, 1'b0, 3'd0, 1'b0);
        ifc.es_to_ms_valid = 1;
        ifc.es_ms_bus      = alu_bus;
        #1; step();
        ifc.es_to_ms_valid = 0;
        #1;
        chk("alu_valid", ifc.ms_to_ws_valid, 1'b1);
        chk("alu_bus", ifc.ms_ws_bus, {32'h1C00_0000, 1'b1, 5'd5, 32'h1234});
        chk("alu_fwd", ms_rf_fwd, {1'b1, 5'd5, 32'h1234});
        chk("alu_dest", ms_dest_reg, 5'd5);
        step();

        // Loads with alignment
        run_load("ldb",  3'd1, 32'h0000_0103, 32'h80FF_0011, 32'hFFFF_FF80);
        run_load("ldbu", 3'd3, 32'h0000_0103, 32'h80FF_0011, 32'h0000_0080);
        run_load("ldh",  3'd2, 32'h0000_0102, 32'h7FFE_1234, 32'h0000_7FFE);
        run_load("ldhu", 3'd4, 32'h0000_0102, 32'hFFFE_0000, 32'h0000_FFFE);

        // Writeback stall at response: the buffered word must be delivered
        ifc.es_to_ms_valid = 1;
        ifc.es_ms_bus      = mk(32'h1C00_0200, 1'b1, 5'd8, 32'h200, 1'b1, 3'd0, 1'b1);
        #1; step();
        ifc.es_to_ms_valid = 0;
        #1; step();
        data_ok         = 1;
        rdata           = 32'h1122_3344;
        ifc.ws_allow_in = 0;
        #1;
        chk("stall_resp_allow", ifc.ms_allow_in, 1'b0);
        chk("stall_resp_res", ifc.ms_ws_bus[31:0], 32'h1122_3344);
        step();
        for (int i = 0; i < 3; i++) begin
            data_ok = 0;
            rdata   = 32'hDEAD_BEEF;
            #1;
            chk("stall_hold_valid", ifc.ms_to_ws_valid, 1'b1);
            chk("stall_hold_allow", ifc.ms_allow_in, 1'b0);
            chk("stall_hold_res", ifc.ms_ws_bus[31:0], 32'h1122_3344);
            step();
        end
        ifc.ws_allow_in = 1;
        #1;
        chk("stall_release_allow", ifc.ms_allow_in, 1'b1);
        chk("stall_release_res", ifc.ms_ws_bus[31:0], 32'h1122_3344);
        step();

        // Back-to-back: ALU op captured on the edge the load leaves
        ifc.es_to_ms_valid = 1;
        ifc.es_ms_bus      = mk(32'h1C00_0300, 1'b1, 5'd9, 32'h300, 1'b1, 3'd0, 1'b1);
        #1; step();
        ifc.es_to_ms_valid = 0;
        #1; step();
        data_ok            = 1;
        rdata              = 32'hCAFE_0001;
        ifc.es_to_ms_valid = 1;
        ifc.es_ms_bus      = mk(32'h1C00_0304, 1'b1, 5'd3, 32'h55, 1'b0, 3'd0, 1'b0);
        #1;
        chk("b2b_allow", ifc.ms_allow_in, 1'b1);
        chk("b2b_load_res", ifc.ms_ws_bus[31:0], 32'hCAFE_0001);
        step();
        ifc.es_to_ms_valid = 0;
        data_ok            = 0;
        #1;
        chk("b2b_alu_valid", ifc.ms_to_ws_valid, 1'b1);
        chk("b2b_alu_bus", ifc.ms_ws_bus, {32'h1C00_0304, 1'b1, 5'd3, 32'h55});
        step();

        // Reset while waiting, then a late response
        ifc.es_to_ms_valid = 1;
        ifc.es_ms_bus      = mk(32'h1C00_0400, 1'b1, 5'd4, 32'h400, 1'b1, 3'd0, 1'b1);
        #1; step();
        ifc.es_to_ms_valid = 0;
        #1; step();
        resetn = 0;
        m_reset();
        #1;
        chk("rstw_allow", ifc.ms_allow_in, 1'b1);
        chk("rstw_valid", ifc.ms_to_ws_valid, 1'b0);
        chk("rstw_dest", ms_dest_reg, 5'd0);
        chk("rstw_fwd", ms_rf_fwd, 38'd0);
        chk("rstw_bus", ifc.ms_ws_bus, 70'd0);
        step();
        resetn  = 1;
        data_ok = 1;
        rdata   = 32'h0BAD_F00D;
        #1;
        chk("late_valid", ifc.ms_to_ws_valid, 1'b0);
        chk("late_allow", ifc.ms_allow_in, 1'b1);
        chk("late_fwd", ms_rf_fwd, 38'd0);
        step();
        data_ok = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit req, waiting;
            req = ($urandom_range(0, 1) == 1);
            ifc.es_to_ms_valid = ($urandom_range(0, 9) < 7);
            ifc.es_ms_bus = mk($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                               $urandom, req ? 1'($urandom_range(0, 1)) : 1'b0,
                               3'($urandom_range(0, 7)), req);
            ifc.ws_allow_in = ($urandom_range(0, 9) < 7);
            rdata           = $urandom;
            waiting         = m_valid && m_bus[0] && !m_resp;
            if (waiting)
                data_ok = (m_age >= 1) && ($urandom_range(0, 9) < 4);
            else
                data_ok = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
